apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 187 ++++++++++++++++++
 tb/tb_apb_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Turns a simple valid/ready command into one APB transfer and returns the
// result on a valid/ready response channel. Only one transfer is in flight
// at a time. The bus protocol is SETUP then ACCESS, and ACCESS repeats until
// the slave raises pready.
//
// Optional feature (macro APB_MASTER_TIMEOUT_EN):
//   Adds a watchdog that ends a transfer after TIMEOUT ACCESS cycles without
//   pready. The transfer then completes with rsp_slverr=1 and rsp_timeout=1.
//   When the macro is not defined, ACCESS waits for pready indefinitely and
//   rsp_timeout is tied low.
//
// Ports:
//   pclk, preset               clock (rising edge), synchronous active-high reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_write, cmd_addr,       command contents
//   cmd_wdata, cmd_strb,
//   cmd_prot
//   rsp_valid / rsp_ready      response handshake
//   rsp_rdata, rsp_slverr,     response contents (rdata is 0 for writes)
//   rsp_timeout
//   psel, penable, pwrite,     APB requester outputs, all registered
//   pprot, paddr, pstrb,
//   pwdata
//   prdata, pready, pslverr    APB completer inputs
//
// State table:
//   state  | meaning
//   IDLE   | cmd_ready high, bus idle, waiting for cmd_valid
//   SETUP  | psel high, penable low, one cycle
//   ACCESS | psel and penable high, waiting for pready (or watchdog)
//   RESP   | rsp_valid high, holding response until rsp_ready
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int         AWIDTH  = 10,
    parameter logic [2:0] DSIZE   = 3'd2,
    parameter int         DBYTES  = 1 << DSIZE,
    parameter int         DWIDTH  = DBYTES * 8,
    parameter int         TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    input  logic [DBYTES-1:0] cmd_strb,
    input  logic [2:0]        cmd_prot,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [2:0]        pprot,
    output logic [AWIDTH-1:0] paddr,
    output logic [DBYTES-1:0] pstrb,
    output logic [DWIDTH-1:0] pwdata,
    input  logic [DWIDTH-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

    // A watchdog limit below one cycle has no meaning; reject it at elaboration.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT must be at least 1");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Down-counter loaded on command accept with TIMEOUT-1, so it reads zero
    // during the TIMEOUT-th ACCESS cycle (terminal count).
    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              rsp_timeout_q;

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            pprot      <= '0;
            paddr      <= '0;
            pstrb      <= '0;
            pwdata     <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wdog_cnt      <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        // The APB output registers double as the command latch.
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        pwrite    <= cmd_write;
                        pprot     <= cmd_prot;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        pstrb     <= cmd_write ? cmd_strb : '0;
`ifdef APB_MASTER_TIMEOUT_EN
                        wdog_cnt  <= WDOG_LOAD;
`endif
                    end
                end

                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end

                ACCESS: begin
                    if (pready) begin
                        state      <= RESP;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= pwrite ? '0 : prdata;
                        rsp_slverr <= pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
                        wdog_cnt      <= '0;
                    end else if (wdog_cnt == '0) begin
                        // Slave never answered: abort, report as an error.
                        state         <= RESP;
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_slverr    <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt - 1'b1;
`endif
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

   logic        pclk = 1'b0;
   logic        preset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [9:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic [2:0]  cmd_prot;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_slverr;
   logic        rsp_timeout;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [2:0]  pprot;
   logic [9:0]  paddr;
   logic [3:0]  pstrb;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int tests = 0;
   int fails = 0;

   always #5 pclk = ~pclk;

   apb_master dut (
      .pclk       (pclk),
      .preset     (preset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_strb   (cmd_strb),
      .cmd_prot   (cmd_prot),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_slverr (rsp_slverr),
      .rsp_timeout(rsp_timeout),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .pprot      (pprot),
      .paddr      (paddr),
      .pstrb      (pstrb),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr)
   );

   task automatic report_fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed simulation still running expected finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int pen_cnt;

      preset    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      cmd_prot  = '0;
      rsp_ready = 1'b0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;

      // ---- reset values ----
      repeat (2) @(negedge pclk);
      tests++; if (cmd_ready   !== 1'b1)    report_fail("rst_cmd_ready",  cmd_ready,   1'b1);
      tests++; if (psel        !== 1'b0)    report_fail("rst_psel",       psel,        1'b0);
      tests++; if (penable     !== 1'b0)    report_fail("rst_penable",    penable,     1'b0);
      tests++; if (pwrite      !== 1'b0)    report_fail("rst_pwrite",     pwrite,      1'b0);
      tests++; if (paddr       !== 10'h000) report_fail("rst_paddr",      paddr,       10'h000);
      tests++; if (pstrb       !== 4'h0)    report_fail("rst_pstrb",      pstrb,       4'h0);
      tests++; if (pwdata      !== 32'h0)   report_fail("rst_pwdata",     pwdata,      32'h0);
      tests++; if (pprot       !== 3'h0)    report_fail("rst_pprot",      pprot,       3'h0);
      tests++; if (rsp_valid   !== 1'b0)    report_fail("rst_rsp_valid",  rsp_valid,   1'b0);
      tests++; if (rsp_rdata   !== 32'h0)   report_fail("rst_rsp_rdata",  rsp_rdata,   32'h0);
      tests++; if (rsp_slverr  !== 1'b0)    report_fail("rst_rsp_slverr", rsp_slverr,  1'b0);
      tests++; if (rsp_timeout !== 1'b0)    report_fail("rst_rsp_to",     rsp_timeout, 1'b0);
      preset = 1'b0;
      @(negedge pclk);
      tests++; if (cmd_ready !== 1'b1) report_fail("rel_cmd_ready", cmd_ready, 1'b1);

      // ---- single write, zero wait states ----
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 10'h004;
      cmd_wdata = 32'hDEADBEEF;
      cmd_strb  = 4'hF;
      cmd_prot  = 3'b010;
      pready    = 1'b1;
      prdata    = 32'hCAFEF00D;
      @(negedge pclk);
      tests++; if (psel      !== 1'b1)         report_fail("wr_setup_psel",    psel,      1'b1);
      tests++; if (penable   !== 1'b0)         report_fail("wr_setup_penable", penable,   1'b0);
      tests++; if (cmd_ready !== 1'b0)         report_fail("wr_setup_ready",   cmd_ready, 1'b0);
      tests++; if (pwrite    !== 1'b1)         report_fail("wr_pwrite",        pwrite,    1'b1);
      tests++; if (paddr     !== 10'h004)      report_fail("wr_paddr",         paddr,     10'h004);
      tests++; if (pwdata    !== 32'hDEADBEEF) report_fail("wr_pwdata",        pwdata,    32'hDEADBEEF);
      tests++; if (pstrb     !== 4'hF)         report_fail("wr_pstrb",         pstrb,     4'hF);
      tests++; if (pprot     !== 3'b010)       report_fail("wr_pprot",         pprot,     3'b010);
      cmd_valid = 1'b0;
      @(negedge pclk);
      tests++; if (psel      !== 1'b1) report_fail("wr_acc_psel",    psel,      1'b1);
      tests++; if (penable   !== 1'b1) report_fail("wr_acc_penable", penable,   1'b1);
      tests++; if (rsp_valid !== 1'b0) report_fail("wr_acc_rvalid",  rsp_valid, 1'b0);
      @(negedge pclk);
      tests++; if (rsp_valid  !== 1'b1)  report_fail("wr_rsp_valid",   rsp_valid,  1'b1);
      tests++; if (rsp_slverr !== 1'b0)  report_fail("wr_rsp_slverr",  rsp_slverr, 1'b0);
      tests++; if (rsp_rdata  !== 32'h0) report_fail("wr_rsp_rdata",   rsp_rdata,  32'h0);
      tests++; if (psel       !== 1'b0)  report_fail("wr_rsp_psel",    psel,       1'b0);
      tests++; if (penable    !== 1'b0)  report_fail("wr_rsp_penable", penable,    1'b0);
      rsp_ready = 1'b1;
      pready    = 1'b0;
      @(negedge pclk);
      tests++; if (rsp_valid !== 1'b0) report_fail("wr_done_rvalid", rsp_valid, 1'b0);
      tests++; if (cmd_ready !== 1'b1) report_fail("wr_done_ready",  cmd_ready, 1'b1);
      rsp_ready = 1'b0;

      // ---- read with three wait states; busy-time cmd and pslverr ignored ----
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 10'h010;
      cmd_strb  = 4'hF;
      cmd_prot  = 3'b000;
      pready    = 1'b0;
      pslverr   = 1'b1;
      prdata    = 32'hBAD0BAD0;
      @(negedge pclk);
      tests++; if (pwrite !== 1'b0)    report_fail("rd_pwrite", pwrite, 1'b0);
      tests++; if (pstrb  !== 4'h0)    report_fail("rd_pstrb",  pstrb,  4'h0);
      tests++; if (paddr  !== 10'h010) report_fail("rd_paddr",  paddr,  10'h010);
      cmd_addr  = 10'h2AA;
      cmd_write = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge pclk);
         tests++; if (penable   !== 1'b1)    report_fail("rd_wait_penable", penable,   1'b1);
         tests++; if (paddr     !== 10'h010) report_fail("rd_wait_paddr",   paddr,     10'h010);
         tests++; if (pwrite    !== 1'b0)    report_fail("rd_wait_pwrite",  pwrite,    1'b0);
         tests++; if (rsp_valid !== 1'b0)    report_fail("rd_wait_rvalid",  rsp_valid, 1'b0);
      end
      @(negedge pclk);
      tests++; if (penable !== 1'b1)    report_fail("rd_last_penable", penable, 1'b1);
      tests++; if (paddr   !== 10'h010) report_fail("rd_last_paddr",   paddr,   10'h010);
      pready  = 1'b1;
      pslverr = 1'b0;
      prdata  = 32'h12345678;
      @(negedge pclk);
      tests++; if (rsp_valid  !== 1'b1)         report_fail("rd_rsp_valid",  rsp_valid,  1'b1);
      tests++; if (rsp_rdata  !== 32'h12345678) report_fail("rd_rsp_rdata",  rsp_rdata,  32'h12345678);
      tests++; if (rsp_slverr !== 1'b0)         report_fail("rd_rsp_slverr", rsp_slverr, 1'b0);
      tests++; if (psel       !== 1'b0)         report_fail("rd_rsp_psel",   psel,       1'b0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      pready    = 1'b0;
      @(negedge pclk);
      tests++; if (cmd_ready !== 1'b1) report_fail("rd_done_ready", cmd_ready, 1'b1);
      tests++; if (psel      !== 1'b0) report_fail("rd_done_psel",  psel,      1'b0);
      rsp_ready = 1'b0;

      // ---- read with slave error, response back-pressured ----
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 10'h3FC;
      pready    = 1'b1;
      pslverr   = 1'b1;
      prdata    = 32'hA5A5A5A5;
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      pslverr = 1'b0;
      prdata  = 32'h0;
      for (int k = 0; k < 5; k++) begin
         tests++; if (rsp_valid  !== 1'b1)         report_fail("err_hold_rvalid", rsp_valid,  1'b1);
         tests++; if (rsp_slverr !== 1'b1)         report_fail("err_hold_slverr", rsp_slverr, 1'b1);
         tests++; if (rsp_rdata  !== 32'hA5A5A5A5) report_fail("err_hold_rdata",  rsp_rdata,  32'hA5A5A5A5);
         tests++; if (cmd_ready  !== 1'b0)         report_fail("err_hold_ready",  cmd_ready,  1'b0);
         tests++; if (psel       !== 1'b0)         report_fail("err_hold_psel",   psel,       1'b0);
         @(negedge pclk);
      end
      rsp_ready = 1'b1;
      @(negedge pclk);
      tests++; if (rsp_valid !== 1'b0) report_fail("err_done_rvalid", rsp_valid, 1'b0);
      tests++; if (cmd_ready !== 1'b1) report_fail("err_done_ready",  cmd_ready, 1'b1);
      rsp_ready = 1'b0;
      pready    = 1'b0;

      // ---- reset during ACCESS ----
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 10'h0C0;
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      tests++; if (penable !== 1'b1) report_fail("rsta_in_access", penable, 1'b1);
      preset = 1'b1;
      @(negedge pclk);
      tests++; if (psel      !== 1'b0) report_fail("rsta_psel",    psel,      1'b0);
      tests++; if (penable   !== 1'b0) report_fail("rsta_penable", penable,   1'b0);
      tests++; if (rsp_valid !== 1'b0) report_fail("rsta_rvalid",  rsp_valid, 1'b0);
      preset = 1'b0;
      @(negedge pclk);
      tests++; if (cmd_ready !== 1'b1) report_fail("rsta_ready", cmd_ready, 1'b1);
      tests++; if (psel      !== 1'b0) report_fail("rsta_idle",  psel,      1'b0);

      // ---- reset with a response pending ----
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 10'h044;
      pready    = 1'b1;
      prdata    = 32'h0F0F0F0F;
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      tests++; if (rsp_valid !== 1'b1) report_fail("rstr_pending", rsp_valid, 1'b1);
      preset = 1'b1;
      @(negedge pclk);
      tests++; if (rsp_valid !== 1'b0)  report_fail("rstr_rvalid", rsp_valid, 1'b0);
      tests++; if (rsp_rdata !== 32'h0) report_fail("rstr_rdata",  rsp_rdata, 32'h0);
      tests++; if (cmd_ready !== 1'b1)  report_fail("rstr_ready",  cmd_ready, 1'b1);
      preset = 1'b0;
      pready = 1'b0;
      @(negedge pclk);

      // ---- pready stuck low ----
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 10'h100;
      prdata    = 32'h77777777;
      @(negedge pclk);
      cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      pen_cnt = 0;
      for (int k = 0; k < 40 && !rsp_valid; k++) begin
         if (penable) pen_cnt++;
         @(negedge pclk);
      end
      tests++; if (rsp_valid   !== 1'b1)  report_fail("to_reached",     rsp_valid,   1'b1);
      tests++; if (pen_cnt     != 16)     report_fail("to_penable_cyc", pen_cnt,     16);
      tests++; if (rsp_slverr  !== 1'b1)  report_fail("to_slverr",      rsp_slverr,  1'b1);
      tests++; if (rsp_timeout !== 1'b1)  report_fail("to_flag",        rsp_timeout, 1'b1);
      tests++; if (rsp_rdata   !== 32'h0) report_fail("to_rdata",       rsp_rdata,   32'h0);
      tests++; if (psel        !== 1'b0)  report_fail("to_psel",        psel,        1'b0);
      rsp_ready = 1'b1;
      @(negedge pclk);
      tests++; if (cmd_ready !== 1'b1) report_fail("to_done_ready", cmd_ready, 1'b1);
      rsp_ready = 1'b0;
`else
      pen_cnt = 0;
      repeat (20) begin
         @(negedge pclk);
         if (penable) pen_cnt++;
      end
      tests++; if (pen_cnt     != 20)    report_fail("nto_penable_cyc", pen_cnt,     20);
      tests++; if (psel        !== 1'b1) report_fail("nto_psel",        psel,        1'b1);
      tests++; if (rsp_valid   !== 1'b0) report_fail("nto_rvalid",      rsp_valid,   1'b0);
      tests++; if (rsp_timeout !== 1'b0) report_fail("nto_flag",        rsp_timeout, 1'b0);
      pready = 1'b1;
      @(negedge pclk);
      tests++; if (rsp_valid   !== 1'b1)         report_fail("nto_rsp_valid", rsp_valid,   1'b1);
      tests++; if (rsp_rdata   !== 32'h77777777) report_fail("nto_rsp_rdata", rsp_rdata,   32'h77777777);
      tests++; if (rsp_timeout !== 1'b0)         report_fail("nto_rsp_flag",  rsp_timeout, 1'b0);
      rsp_ready = 1'b1;
      pready    = 1'b0;
      @(negedge pclk);
      tests++; if (cmd_ready !== 1'b1) report_fail("nto_done_ready", cmd_ready, 1'b1);
      rsp_ready = 1'b0;
`endif

      // ---- back-to-back commands ----
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_wdata = 32'h01020304;
      cmd_strb  = 4'h3;
      rsp_ready = 1'b1;
      pready    = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tests++;
         if (cmd_ready !== (i % 4 == 0))
            report_fail("b2b_cmd_ready", cmd_ready, (i % 4 == 0));
         tests++;
         if (psel !== ((i % 4 == 1) || (i % 4 == 2)))
            report_fail("b2b_psel", psel, ((i % 4 == 1) || (i % 4 == 2)));
         if (i % 4 == 1) begin
            tests++;
            if (paddr !== 10'(12'h100 + i - 1))
               report_fail("b2b_paddr", paddr, 10'(12'h100 + i - 1));
         end
         if (i % 4 == 0) cmd_addr = 10'(12'h100 + i);
         @(negedge pclk);
      end
      tests++; if (cmd_ready !== 1'b1) report_fail("b2b_end_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      pready    = 1'b0;
      repeat (2) @(negedge pclk);
      tests++; if (psel !== 1'b0) report_fail("b2b_quiet_psel", psel, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
